// File: rtl/mini_core_rrv_pkg.sv
// Shared types for the mini_core_rrv RV32M multiply/divide sequencer.
// Holds the funct3 op encoding, the FSM states, the request bundle and operand-sign helpers.
package mini_core_rrv_pkg;

    localparam int RRV_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } t_muldiv_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } t_muldiv_state;

    typedef struct packed {
        t_muldiv_op            op;
        logic [RRV_XLEN-1:0]   in1;
        logic [RRV_XLEN-1:0]   in2;
        logic [4:0]            rd;
    } t_muldiv_req;

    // MUL shares its low word with every signedness, so it is treated as signed*signed.
    function automatic logic op_in1_signed(input t_muldiv_op op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_in2_signed(input t_muldiv_op op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mini_core_rrv_muldiv_dp.sv
// Shared multiply/divide datapath: one shift-add or restoring-divide iteration per step.
// hi/lo hold accumulator/multiplier for MUL and remainder/quotient for DIV; m is the fixed operand.
module mini_core_rrv_muldiv_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_nxt_o,
    output logic [XLEN-1:0] lo_nxt_o
);

    logic [XLEN-1:0] hi_q, lo_q, m_q;
    logic            div_q;
    logic [XLEN:0]   sum, shifted, diff;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hi_nxt_o = hi_q;
        lo_nxt_o = lo_q;
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted  = {hi_q, lo_q[XLEN-1]};
        diff     = shifted - {1'b0, m_q};
        if (div_q) begin
            // diff[XLEN] is the borrow: set means the trial subtraction is discarded.
            if (diff[XLEN]) begin
                hi_nxt_o = shifted[XLEN-1:0];
                lo_nxt_o = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_nxt_o = diff[XLEN-1:0];
                lo_nxt_o = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_nxt_o = sum[XLEN:1];
            lo_nxt_o = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= is_div_i ? a_i : b_i;
            m_q   <= is_div_i ? b_i : a_i;
            div_q <= is_div_i;
        end else if (step_i) begin
            hi_q  <= hi_nxt_o;
            lo_q  <= lo_nxt_o;
        end
    end

endmodule

// File: rtl/mini_core_rrv_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the Q101H ALU: accepts one op, stalls Q101H while
// iterating, then pulses one result for Q102H writeback. Owns FSM, counter, signs, special cases.
module mini_core_rrv_muldiv_ctrl
    import mini_core_rrv_pkg::*;
#(
    parameter int XLEN      = RRV_XLEN,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic            Clock,
    input  logic            Rst,
    input  logic            ReqValidQ101H,
    input  logic [2:0]      ReqOpQ101H,
    input  logic [XLEN-1:0] ReqIn1Q101H,
    input  logic [XLEN-1:0] ReqIn2Q101H,
    input  logic [4:0]      ReqRdQ101H,
    input  logic            Flush,
    output logic            ReqReady,
    output logic            StallQ101H,
    output logic            RspValid,
    output logic [XLEN-1:0] RspData,
    output logic [4:0]      RspRd,
    output logic            Busy
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    t_muldiv_state   state_q;
    t_muldiv_op      op_q;
    logic [4:0]      rd_q, rsp_rd_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic [XLEN-1:0] rsp_data_q;

    t_muldiv_req       req;
    logic              accept, is_div, is_rem, in1_neg, in2_neg, div0, ovf, special, neg_d;
    logic [XLEN-1:0]   mag1, mag2, special_data;
    logic [XLEN-1:0]   dp_hi, dp_lo, div_sel, fin_data;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        req.op  = t_muldiv_op'(ReqOpQ101H);
        req.in1 = ReqIn1Q101H;
        req.in2 = ReqIn2Q101H;
        req.rd  = ReqRdQ101H;

        accept  = (state_q == IDLE) && ReqValidQ101H && !Flush;
        is_div  = req.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_rem  = req.op inside {OP_REM, OP_REMU};
        in1_neg = op_in1_signed(req.op) && req.in1[XLEN-1];
        in2_neg = op_in2_signed(req.op) && req.in2[XLEN-1];
        mag1    = in1_neg ? -req.in1 : req.in1;
        mag2    = in2_neg ? -req.in2 : req.in2;
        div0    = (req.in2 == '0);
        ovf     = (req.op inside {OP_DIV, OP_REM}) && (req.in1 == INT_MIN) && (&req.in2);
        special = FAST_DIV0 && is_div && (div0 || ovf);

        if (div0) special_data = is_rem ? req.in1 : '1;
        else      special_data = is_rem ? '0 : INT_MIN;

        // The loop already yields all-ones for x/0; suppressing the negate keeps it that way.
        if (!is_div)     neg_d = in1_neg ^ in2_neg;
        else if (is_rem) neg_d = in1_neg;
        else             neg_d = (in1_neg ^ in2_neg) && !div0;
    end

    // Final result is taken from the datapath's last-step value so it lands together with DONE.
    always_comb begin
        prod     = {dp_hi, dp_lo};
        prod_fix = neg_q ? -prod : prod;
        div_sel  = (op_q inside {OP_REM, OP_REMU}) ? dp_hi : dp_lo;
        if (state_q == DIV)      fin_data = neg_q ? -div_sel : div_sel;
        else if (op_q == OP_MUL) fin_data = prod_fix[XLEN-1:0];
        else                     fin_data = prod_fix[2*XLEN-1:XLEN];
    end

    mini_core_rrv_muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk_i    (Clock),
        .rst_ni   (Rst),
        .start_i  (accept && !special),
        .step_i   ((state_q == MUL) || (state_q == DIV)),
        .is_div_i (is_div),
        .a_i      (mag1),
        .b_i      (mag2),
        .hi_nxt_o (dp_hi),
        .lo_nxt_o (dp_lo)
    );

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            rd_q       <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= req.op;
                        rd_q  <= req.rd;
                        neg_q <= neg_d;
                        cnt_q <= CW'(XLEN - 1);
                        if (special) begin
                            state_q    <= DONE;
                            rsp_data_q <= special_data;
                            rsp_rd_q   <= req.rd;
                        end else begin
                            state_q <= is_div ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (Flush) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q    <= DONE;
                        rsp_data_q <= fin_data;
                        rsp_rd_q   <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ReqReady   = (state_q == IDLE);
    assign Busy       = (state_q != IDLE);
    assign StallQ101H = accept || (state_q == MUL) || (state_q == DIV);
    assign RspValid   = (state_q == DONE) && !Flush;
    assign RspData    = rsp_data_q;
    assign RspRd      = rsp_rd_q;

endmodule

// File: tb/tb_mini_core_rrv_muldiv_ctrl.sv
// Self-checking bench for mini_core_rrv_muldiv_ctrl: directed table, corner sequences and
// randomized ops compared against a plain-arithmetic RV32M reference model.
module tb_mini_core_rrv_muldiv_ctrl;

    localparam bit          FAST    = 1'b1;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        Clock, Rst, ReqValidQ101H, Flush;
    logic [2:0]  ReqOpQ101H;
    logic [31:0] ReqIn1Q101H, ReqIn2Q101H;
    logic [4:0]  ReqRdQ101H;
    logic        ReqReady, StallQ101H, RspValid, Busy;
    logic [31:0] RspData;
    logic [4:0]  RspRd;

    int checks   = 0;
    int failures = 0;

    mini_core_rrv_muldiv_ctrl #(.XLEN(32), .FAST_DIV0(FAST)) dut (
        .Clock         (Clock),
        .Rst           (Rst),
        .ReqValidQ101H (ReqValidQ101H),
        .ReqOpQ101H    (ReqOpQ101H),
        .ReqIn1Q101H   (ReqIn1Q101H),
        .ReqIn2Q101H   (ReqIn2Q101H),
        .ReqRdQ101H    (ReqRdQ101H),
        .Flush         (Flush),
        .ReqReady      (ReqReady),
        .StallQ101H    (StallQ101H),
        .RspValid      (RspValid),
        .RspData       (RspData),
        .RspRd         (RspRd),
        .Busy          (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'b0, b});
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0)                           r = 32'hFFFF_FFFF;
                else if (a == INT_MIN && b == '1)     r = INT_MIN;
                else                                  r = 32'(sa / sb);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)                           r = a;
                else if (a == INT_MIN && b == '1)     r = '0;
                else                                  r = 32'(sa % sb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        bit ovf;
        ovf = (op == 3'd4 || op == 3'd6) && a == INT_MIN && b == '1;
        if (FAST && op >= 3'd4 && (b == 0 || ovf)) return 1;
        return 33;
    endfunction

    // Issues one op in the current cycle N and waits for its response.
    // lat is cycles after N (-1 if none within budget); stall_ok covers cycles N..response.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] data,
                          output logic [4:0] rrd, output bit stall_ok, output bit ready0,
                          output bit busy0);
        ReqValidQ101H = 1'b1;
        ReqOpQ101H    = op;
        ReqIn1Q101H   = a;
        ReqIn2Q101H   = b;
        ReqRdQ101H    = rd;
        @(negedge Clock);
        ready0   = ReqReady;
        busy0    = Busy;
        stall_ok = (StallQ101H === 1'b1);
        @(posedge Clock); #1;
        ReqValidQ101H = 1'b0;
        ReqIn1Q101H   = $urandom;
        ReqIn2Q101H   = $urandom;
        lat  = -1;
        data = '0;
        rrd  = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            if (RspValid === 1'b1) begin
                lat  = k;
                data = RspData;
                rrd  = RspRd;
                if (StallQ101H !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (StallQ101H !== 1'b1) stall_ok = 1'b0;
            @(posedge Clock); #1;
        end
        @(posedge Clock); #1;
    endtask

    task automatic verify_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd,
                             input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] data;
        logic [4:0]  rrd;
        bit          stall_ok, ready0, busy0;
        run_op(op, a, b, rd, lat, data, rrd, stall_ok, ready0, busy0);
        check($sformatf("%s op%0d lat", tag, op), 64'(lat), 64'(exp_lat));
        check($sformatf("%s op%0d data a=%h b=%h", tag, op, a, b), {32'b0, data}, {32'b0, exp});
        check($sformatf("%s op%0d rd", tag, op), {59'b0, rrd}, {59'b0, rd});
        check($sformatf("%s op%0d stall", tag, op), {63'b0, stall_ok}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return INT_MIN;
            3:       return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int          lat, rsp_cnt, idx;
        logic [31:0] data, exp_q[$];
        logic [4:0]  rrd;
        bit          stall_ok, ready0, busy0, adv;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [2:0]  b2b_op[3];
        logic [31:0] b2b_a[3], b2b_b[3];

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd0, 32'd12345,     32'd0,         32'd0,         33};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[7]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[8]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[9]  = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[10] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[11] = '{3'd4, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1};
        vecs[12] = '{3'd6, 32'd1234,      32'd0,         32'd1234,      1};
        vecs[13] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{3'd7, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1};
        vecs[15] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[16] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[17] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[18] = '{3'd2, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 33};

        Rst = 1'b0; ReqValidQ101H = 1'b0; Flush = 1'b0;
        ReqOpQ101H = '0; ReqIn1Q101H = '0; ReqIn2Q101H = '0; ReqRdQ101H = '0;
        repeat (3) @(posedge Clock);
        #1 Rst = 1'b1;

        @(negedge Clock);
        check("reset ReqReady", {63'b0, ReqReady}, 64'd1);
        check("reset Stall", {63'b0, StallQ101H}, 64'd0);
        check("reset RspValid", {63'b0, RspValid}, 64'd0);
        check("reset RspData", {32'b0, RspData}, 64'd0);
        check("reset RspRd", {59'b0, RspRd}, 64'd0);
        check("reset Busy", {63'b0, Busy}, 64'd0);
        @(posedge Clock); #1;

        for (int i = 0; i < 19; i++)
            verify_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                      vecs[i].exp, vecs[i].lat);

        // Flush wins over accept in the same cycle.
        ReqValidQ101H = 1'b1; ReqOpQ101H = 3'd0; ReqIn1Q101H = 32'd3; ReqIn2Q101H = 32'd3;
        Flush = 1'b1;
        @(negedge Clock);
        check("flush+req stall", {63'b0, StallQ101H}, 64'd0);
        @(posedge Clock); #1;
        ReqValidQ101H = 1'b0; Flush = 1'b0;
        @(negedge Clock);
        check("flush+req busy", {63'b0, Busy}, 64'd0);
        @(posedge Clock); #1;

        // Flush at N+10 of a DIV, then a MUL issued at N+11.
        ReqValidQ101H = 1'b1; ReqOpQ101H = 3'd4; ReqIn1Q101H = 32'd1000; ReqIn2Q101H = 32'd3;
        ReqRdQ101H = 5'd9;
        @(posedge Clock); #1;
        ReqValidQ101H = 1'b0;
        rsp_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) Flush = 1'b1;
            @(negedge Clock);
            if (RspValid === 1'b1) rsp_cnt++;
            @(posedge Clock); #1;
            Flush = 1'b0;
        end
        run_op(3'd0, 32'hFFFF_FFF6, 32'd6, 5'd17, lat, data, rrd, stall_ok, ready0, busy0);
        check("flush no rsp", 64'(rsp_cnt), 64'd0);
        check("flush busy N+11", {63'b0, busy0}, 64'd0);
        check("flush ready N+11", {63'b0, ready0}, 64'd1);
        check("post-flush mul lat", 64'(lat), 64'd33);
        check("post-flush mul data", {32'b0, data}, {32'b0, model(3'd0, 32'hFFFF_FFF6, 32'd6)});
        check("post-flush mul rd", {59'b0, rrd}, 64'd17);

        // One-cycle reset in the middle of a MUL.
        ReqValidQ101H = 1'b1; ReqOpQ101H = 3'd3; ReqIn1Q101H = 32'hDEAD_BEEF;
        ReqIn2Q101H = 32'h1234_5678; ReqRdQ101H = 5'd5;
        @(posedge Clock); #1;
        ReqValidQ101H = 1'b0;
        repeat (15) @(posedge Clock);
        #1 Rst = 1'b0;
        @(posedge Clock); #1;
        Rst = 1'b1;
        @(negedge Clock);
        check("midrst ReqReady", {63'b0, ReqReady}, 64'd1);
        check("midrst Stall", {63'b0, StallQ101H}, 64'd0);
        check("midrst RspValid", {63'b0, RspValid}, 64'd0);
        check("midrst RspData", {32'b0, RspData}, 64'd0);
        check("midrst RspRd", {59'b0, RspRd}, 64'd0);
        check("midrst Busy", {63'b0, Busy}, 64'd0);
        rsp_cnt = 0;
        repeat (40) begin
            @(negedge Clock);
            if (RspValid === 1'b1) rsp_cnt++;
        end
        check("midrst no rsp", 64'(rsp_cnt), 64'd0);
        @(posedge Clock); #1;

        // Back-to-back: ReqValid stays high, the pipeline advances whenever Stall is low.
        b2b_op = '{3'd0, 3'd3, 3'd5};
        b2b_a  = '{32'd3, 32'hFFFF_0000, 32'd1000};
        b2b_b  = '{32'd5, 32'h0001_0000, 32'd0};
        for (int i = 0; i < 3; i++) exp_q.push_back(model(b2b_op[i], b2b_a[i], b2b_b[i]));
        idx = 0; rsp_cnt = 0;
        ReqValidQ101H = 1'b1; ReqOpQ101H = b2b_op[0]; ReqIn1Q101H = b2b_a[0];
        ReqIn2Q101H = b2b_b[0]; ReqRdQ101H = 5'd20;
        for (int c = 0; c < 200 && idx < 3; c++) begin
            @(negedge Clock);
            adv = ReqValidQ101H && (StallQ101H === 1'b0);
            if (RspValid === 1'b1) begin
                if (exp_q.size() > 0)
                    check($sformatf("b2b rsp%0d data", rsp_cnt), {32'b0, RspData},
                          {32'b0, exp_q.pop_front()});
                else
                    check("b2b extra rsp", 64'd1, 64'd0);
                rsp_cnt++;
            end
            @(posedge Clock); #1;
            if (adv) begin
                idx++;
                if (idx < 3) begin
                    ReqOpQ101H = b2b_op[idx]; ReqIn1Q101H = b2b_a[idx];
                    ReqIn2Q101H = b2b_b[idx]; ReqRdQ101H = 5'(20 + idx);
                end else begin
                    ReqValidQ101H = 1'b0;
                end
            end
        end
        ReqValidQ101H = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            if (RspValid === 1'b1) rsp_cnt++;
        end
        check("b2b rsp count", 64'(rsp_cnt), 64'd3);
        @(posedge Clock); #1;

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(7));
            ra  = pick();
            rb  = pick();
            verify_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(31)),
                      model(rop, ra, rb), model_lat(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
